// File: rtl/fdtd_ctrl_regs_if.sv
// Register-access bus between the AXI word adapters and the FDTD control bank.
interface fdtd_ctrl_regs_if #(
    parameter int unsigned AXI4_DATA_WIDTH = 32,
    parameter int unsigned WORD_ADDR_WIDTH = 4
);
    localparam int unsigned STRB_WIDTH = AXI4_DATA_WIDTH / 8;

    logic                       rd_avalid_i;
    logic [WORD_ADDR_WIDTH-1:0] rd_word_addr_i;
    logic [AXI4_DATA_WIDTH-1:0] rd_data_o;
    logic                       wr_avalid_i;
    logic [WORD_ADDR_WIDTH-1:0] wr_word_addr_i;
    logic [AXI4_DATA_WIDTH-1:0] wr_data_i;
    logic [STRB_WIDTH-1:0]      wr_strb_i;

    modport master (
        output rd_avalid_i, rd_word_addr_i,
        input  rd_data_o,
        output wr_avalid_i, wr_word_addr_i, wr_data_i, wr_strb_i
    );

    modport slave (
        input  rd_avalid_i, rd_word_addr_i,
        output rd_data_o,
        input  wr_avalid_i, wr_word_addr_i, wr_data_i, wr_strb_i
    );
endinterface

// File: rtl/fdtd_ctrl_regs.sv
// FDTD engine control/status registers and E/H phase run sequencer.
module fdtd_ctrl_regs #(
    parameter int unsigned AXI4_DATA_WIDTH = 32,
    parameter int unsigned WORD_ADDR_WIDTH = 4,
    parameter int unsigned STEP_WIDTH      = 16
) (
    input  logic            ACLK,
    input  logic            ARESETn,
    fdtd_ctrl_regs_if.slave bus,
    output logic            eng_start_o,
    output logic            eng_phase_o,
    input  logic            eng_done_i,
    output logic            irq_o
);
    localparam int unsigned DW = AXI4_DATA_WIDTH;
    localparam logic [WORD_ADDR_WIDTH-1:0] ADDR_CTRL   = WORD_ADDR_WIDTH'(0);
    localparam logic [WORD_ADDR_WIDTH-1:0] ADDR_STATUS = WORD_ADDR_WIDTH'(1);
    localparam logic [WORD_ADDR_WIDTH-1:0] ADDR_NSTEPS = WORD_ADDR_WIDTH'(2);
    localparam logic [WORD_ADDR_WIDTH-1:0] ADDR_STEP   = WORD_ADDR_WIDTH'(3);
    localparam logic [WORD_ADDR_WIDTH-1:0] ADDR_CYCLE  = WORD_ADDR_WIDTH'(4);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START_E = 3'd1,
        S_WAIT_E  = 3'd2,
        S_START_H = 3'd3,
        S_WAIT_H  = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic                  irq_en_q, irq_en_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic                  abort_pend_q, abort_pend_d;
    logic [STEP_WIDTH-1:0] nsteps_q, nsteps_d;
    logic [STEP_WIDTH-1:0] step_cnt_q, step_cnt_d;
    logic [31:0]           cycle_cnt_q, cycle_cnt_d;
    logic                  eng_start_q, eng_start_d;
    logic                  eng_phase_q, eng_phase_d;
    logic                  irq_q, irq_d;

    logic wr_ctrl_c, wr_status_c, wr_nsteps_c;
    logic start_req_c, abort_req_c;
    logic busy_c, run_accept_c, zero_run_c;
    logic wait_done_c, h_done_c, last_step_c;
    logic [DW-1:0] rd_data_c;

    // Bits of the bus that carry no meaning for this register map.
    logic unused_ok;
    assign unused_ok = ^{bus.rd_avalid_i, bus.wr_data_i, bus.wr_strb_i};

    // Write decode and run-event qualifiers.
    always_comb begin
        wr_ctrl_c    = bus.wr_avalid_i && (bus.wr_word_addr_i == ADDR_CTRL);
        wr_status_c  = bus.wr_avalid_i && (bus.wr_word_addr_i == ADDR_STATUS) && bus.wr_strb_i[0];
        wr_nsteps_c  = bus.wr_avalid_i && (bus.wr_word_addr_i == ADDR_NSTEPS);
        start_req_c  = wr_ctrl_c && bus.wr_strb_i[0] && bus.wr_data_i[0];
        abort_req_c  = wr_ctrl_c && bus.wr_strb_i[0] && bus.wr_data_i[1];
        busy_c       = (state_q != S_IDLE);
        run_accept_c = !busy_c && start_req_c && (nsteps_q != '0);
        zero_run_c   = !busy_c && start_req_c && (nsteps_q == '0);
        wait_done_c  = eng_done_i && ((state_q == S_WAIT_E) || (state_q == S_WAIT_H));
        h_done_c     = eng_done_i && (state_q == S_WAIT_H);
        last_step_c  = ((step_cnt_q + STEP_WIDTH'(1)) == nsteps_q);
    end

    // All flops, asynchronously cleared.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= S_IDLE;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            nsteps_q     <= '0;
            step_cnt_q   <= '0;
            cycle_cnt_q  <= '0;
            eng_start_q  <= 1'b0;
            eng_phase_q  <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
            nsteps_q     <= nsteps_d;
            step_cnt_q   <= step_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            eng_start_q  <= eng_start_d;
            eng_phase_q  <= eng_phase_d;
            irq_q        <= irq_d;
        end
    end

    // Sequencer next state: alternate E and H phases until NSTEPS or abort.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (run_accept_c) state_d = S_START_E;
            S_START_E: state_d = S_WAIT_E;
            S_WAIT_E:  if (eng_done_i) state_d = abort_pend_q ? S_IDLE : S_START_H;
            S_START_H: state_d = S_WAIT_H;
            S_WAIT_H:  if (eng_done_i) state_d = (abort_pend_q || last_step_c) ? S_IDLE : S_START_E;
            default:   state_d = S_IDLE;
        endcase
    end

    // Register updates and registered engine/irq outputs.
    always_comb begin
        irq_en_d     = irq_en_q;
        done_d       = done_q;
        aborted_d    = aborted_q;
        abort_pend_d = abort_pend_q;
        nsteps_d     = nsteps_q;
        step_cnt_d   = step_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;

        if (wr_ctrl_c && bus.wr_strb_i[0]) irq_en_d = bus.wr_data_i[2];

        if (wr_nsteps_c && !busy_c) begin
            for (int unsigned i = 0; i < STEP_WIDTH; i++) begin
                if (bus.wr_strb_i[i / 8]) nsteps_d[i] = bus.wr_data_i[i];
            end
        end

        // Clears first so that a same-cycle hardware set wins.
        if (wr_status_c && bus.wr_data_i[1]) done_d    = 1'b0;
        if (wr_status_c && bus.wr_data_i[2]) aborted_d = 1'b0;

        if (run_accept_c) begin
            done_d      = 1'b0;
            aborted_d   = 1'b0;
            step_cnt_d  = '0;
            cycle_cnt_d = '0;
        end else if (busy_c && (cycle_cnt_q != '1)) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end

        if (h_done_c) step_cnt_d = step_cnt_q + STEP_WIDTH'(1);
        if (zero_run_c || (h_done_c && !abort_pend_q && last_step_c)) done_d = 1'b1;
        if (wait_done_c && abort_pend_q) aborted_d = 1'b1;

        if (busy_c && abort_req_c) abort_pend_d = 1'b1;
        if (state_d == S_IDLE)     abort_pend_d = 1'b0;

        eng_start_d = (state_d == S_START_E) || (state_d == S_START_H);
        eng_phase_d = (state_d == S_START_H) || (state_d == S_WAIT_H);
        irq_d       = irq_en_d && (done_d || aborted_d);
    end

    // Combinational read mux, independent of the read strobe.
    always_comb begin
        rd_data_c = '0;
        unique case (bus.rd_word_addr_i)
            ADDR_CTRL:   rd_data_c = {{(DW-3){1'b0}}, irq_en_q, 2'b00};
            ADDR_STATUS: rd_data_c = {{(DW-3){1'b0}}, aborted_q, done_q, busy_c};
            ADDR_NSTEPS: rd_data_c = DW'(nsteps_q);
            ADDR_STEP:   rd_data_c = DW'(step_cnt_q);
            ADDR_CYCLE:  rd_data_c = DW'(cycle_cnt_q);
            default:     rd_data_c = '0;
        endcase
    end

    assign bus.rd_data_o = rd_data_c;
    assign eng_start_o   = eng_start_q;
    assign eng_phase_o   = eng_phase_q;
    assign irq_o         = irq_q;
endmodule
